sar_adc_ctrl_mc: RTL
====================

Name: sar_adc_ctrl_mc

Overview:
- Parametrised, multi-channel successor SAR ADC controller; drives the external sample/hold, the N-bit trial DAC and the analog input mux; reads the comparator.
- Adds configurable resolution, channel count, sample and DAC-settle durations, and a start-collision policy.
- Publishes each result with its channel tag and a one-cycle valid strobe.
- Sits between the analog front end and the digital sample consumer.

Parameters:
- WIDTH, 8, conversion resolution in bits (2..16).
- NUM_CH, 4, number of analog input channels (1..16).
- SAMPLE_CYCLES, 2, cycles SH is held high (>=1).
- SETTLE_CYCLES, 1, DAC settle cycles before each comparator decision (>=0).

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous active-low reset.
- nStartCnv  in  1  active-low start request, level-sensitive, sampled in IDLE only.
- chSel  in  clog2(NUM_CH) (min 1)  channel to convert; captured on start acceptance.
- CompOut  in  1  comparator: 1 = DAC trial value above input.
- SH  out  1  sample/hold control, 1 = sample.
- chMux  out  clog2(NUM_CH)  analog mux select; held stable for the whole conversion.
- B  out  WIDTH  trial DAC code.
- nEndCnv  out  1  low = idle/ended, high = conversion in progress.
- dataOut  out  WIDTH  last completed result.
- dataCh  out  clog2(NUM_CH)  channel of dataOut.
- dataValid  out  1  one-cycle pulse when dataOut/dataCh update.

Behaviour:
- Reset: one clock, one synchronous active-low reset, as already decided. On a clock edge with reset==0: state IDLE; SH=0, B=0, chMux=0, nEndCnv=0, dataOut=0, dataCh=0, dataValid=0; all counters 0. Reset mid-conversion aborts immediately; no partial result is published.
- States: IDLE, SAMPLE, HOLD, TRIAL, SETTLE, DECIDE, STORE, DONE.
- IDLE:
  - If nStartCnv==0: chMux<=chSel (out-of-range value clamps to NUM_CH-1), SH<=1, nEndCnv<=1, B<=0, go to SAMPLE.
- SAMPLE:
  - Stays SAMPLE_CYCLES cycles.
  - Then SH<=0 and go to HOLD.
- HOLD: one cycle; bit index k<=WIDTH-1; go to TRIAL.
- TRIAL: B[k]<=1; go to SETTLE, or directly to DECIDE if SETTLE_CYCLES==0.
- SETTLE: SETTLE_CYCLES cycles, then DECIDE.
- DECIDE:
  - If CompOut==1, B[k]<=0.
  - If k==0 go to STORE; else k<=k-1 and go to TRIAL.
- STORE: dataOut<=final B (with the DECIDE correction applied), dataCh<=chMux, dataValid<=1; go to DONE.
- DONE: dataValid<=0, nEndCnv<=0; go to IDLE.
- Latency from the start-acceptance edge to the dataValid-high edge = SAMPLE_CYCLES + 1 + WIDTH*(2+SETTLE_CYCLES) + 1 cycles (defaults: 28).
- nEndCnv is high exactly from the cycle after acceptance through DONE.
- Start requests are ignored outside IDLE. If nStartCnv is held low, back-to-back conversions start on the first IDLE cycle.
- chSel changes during a conversion have no effect.
- B, SH and chMux change only on clock edges and never glitch between states.
- Comparator boundary cases: all-CompOut=1 yields code 0; all-CompOut=0 yields code 2^WIDTH-1.

Optional Feature:
- Macro SAR_ADC_SCAN_EN.
- When defined:
  - Adds input scanEn (1 bit).
  - While scanEn==1 the block ignores chSel and nStartCnv.
  - Conversions run continuously, channel 0,1,...,NUM_CH-1, then wrap to 0.
  - DONE goes straight to SAMPLE of the next channel with nEndCnv staying high.
  - Deasserting scanEn finishes the current conversion, then returns to IDLE.
- When undefined: no scanEn port; single-shot behaviour only.

Decomposition:
- Package sar_adc_pkg:
  - State enum type.
  - CH_W = clog2 helper function.
  - Comparator polarity constant COMP_ABOVE = 1'b1.
- Sub-module sar_adc_cnt: shared down-counter used for the SAMPLE and SETTLE durations (load value, decrement, zero flag).

Test Plan:
- Defaults; comparator model CompOut = (B > 8'hA5); nStartCnv pulsed low with chSel=2 → dataOut=8'hA5, dataCh=2, one-cycle dataValid exactly 28 cycles after acceptance; nEndCnv high throughout.
- Comparator models CompOut=1 constantly, then CompOut=0 constantly → dataOut=8'h00, then 8'hFF.
- Reset pulled low mid-conversion (during bit 4 DECIDE) → next edge: SH=0, B=0, nEndCnv=0, no dataValid; next conversion targeting 8'h3C gives 8'h3C.
- WIDTH=12, SETTLE_CYCLES=3, target 12'h5A7 → dataOut=12'h5A7 after 2+1+60+1=64 cycles.
- nStartCnv held low continuously with chSel toggled mid-conversion → back-to-back results; each dataCh equals chSel at its acceptance edge; no start is lost or duplicated.
- SAR_ADC_SCAN_EN defined, NUM_CH=4, scanEn=1, per-channel targets 10,20,30,40 → dataCh sequence 0,1,2,3,0 with matching dataOut values; scanEn dropped during channel 1 → channel 1 completes, then IDLE with nEndCnv=0.

Source files
------------

// File: rtl/sar_adc_ctrl_mc_pkg.sv
// ============================================================================
// Module      : sar_adc_pkg
// Description : Shared types and helpers for the multi-channel SAR ADC
//               controller (state encoding, channel-width helper, comparator
//               polarity).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package sar_adc_pkg;

  // Controller states; the 3-bit encoding is fixed so waveforms stay stable.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SAMPLE = 3'd1,
    ST_HOLD   = 3'd2,
    ST_TRIAL  = 3'd3,
    ST_SETTLE = 3'd4,
    ST_DECIDE = 3'd5,
    ST_STORE  = 3'd6,
    ST_DONE   = 3'd7
  } state_e;

  // Comparator level meaning "trial DAC value is above the held input".
  localparam logic COMP_ABOVE = 1'b1;

  // Width of a channel index; a single channel still needs one bit.
  function automatic int ch_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

`default_nettype wire

// File: rtl/sar_adc_ctrl_mc_if.sv
// ============================================================================
// Module      : sar_adc_ctrl_mc_if
// Description : Analog front-end / result bus of the SAR ADC controller.
//               master = controller side, slave = front end and consumer.
//               Optional scan input present when SAR_ADC_SCAN_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface sar_adc_ctrl_mc_if #(
  parameter int WIDTH  = 8,
  parameter int NUM_CH = 4
);
  import sar_adc_pkg::*;

  localparam int CH_W = ch_w(NUM_CH);

  logic              nStartCnv;
  logic [CH_W-1:0]   chSel;
  logic              CompOut;
`ifdef SAR_ADC_SCAN_EN
  logic              scanEn;
`endif
  logic              SH;
  logic [CH_W-1:0]   chMux;
  logic [WIDTH-1:0]  B;
  logic              nEndCnv;
  logic [WIDTH-1:0]  dataOut;
  logic [CH_W-1:0]   dataCh;
  logic              dataValid;

  modport master (
    input  nStartCnv, chSel, CompOut,
`ifdef SAR_ADC_SCAN_EN
    input  scanEn,
`endif
    output SH, chMux, B, nEndCnv, dataOut, dataCh, dataValid
  );

  modport slave (
    output nStartCnv, chSel, CompOut,
`ifdef SAR_ADC_SCAN_EN
    output scanEn,
`endif
    input  SH, chMux, B, nEndCnv, dataOut, dataCh, dataValid
  );

endinterface

`default_nettype wire

// File: rtl/sar_adc_ctrl_mc_cnt.sv
// ============================================================================
// Module      : sar_adc_cnt
// Description : Loadable down-counter shared by the sample and DAC-settle
//               intervals. Load wins over decrement; saturates at zero.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sar_adc_cnt #(
  parameter int W = 16
) (
  input  wire logic         clock,
  input  wire logic         reset,
  input  wire logic         load_i,
  input  wire logic [W-1:0] val_i,
  input  wire logic         dec_i,
  output logic              zero_o
);

  logic [W-1:0] cnt_q;

  // Counter register: load a duration, then count it down to zero.
  always_ff @(posedge clock) begin
    if (!reset) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_q <= cnt_q - W'(1);
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

`default_nettype wire

// File: rtl/sar_adc_ctrl_mc.sv
// ============================================================================
// Module      : sar_adc_ctrl_mc
// Description : Parametrised multi-channel SAR ADC controller. Drives the
//               sample/hold, trial DAC and input mux, reads the comparator
//               and publishes each result with its channel tag.
//               Optional feature macro: SAR_ADC_SCAN_EN (continuous
//               round-robin scan of all channels while scanEn is high).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sar_adc_ctrl_mc
  import sar_adc_pkg::*;
#(
  parameter int WIDTH         = 8,
  parameter int NUM_CH        = 4,
  parameter int SAMPLE_CYCLES = 2,
  parameter int SETTLE_CYCLES = 1
) (
  input wire logic           clock,
  input wire logic           reset,
  sar_adc_ctrl_mc_if.master  bus
);

  localparam int CH_W  = ch_w(NUM_CH);
  localparam int K_W   = $clog2(WIDTH);
  localparam int CNT_W = 16;

  localparam logic [CH_W-1:0]  MAX_CH    = CH_W'(NUM_CH - 1);
  localparam logic [K_W-1:0]   TOP_K     = K_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] SAMPLE_LD = CNT_W'(SAMPLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);

  state_e             state_q, state_d;
  logic               sh_q, sh_d;
  logic [CH_W-1:0]    chmux_q, chmux_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic               nend_q, nend_d;
  logic [WIDTH-1:0]   dout_q, dout_d;
  logic [CH_W-1:0]    dch_q, dch_d;
  logic               dvalid_q, dvalid_d;
  logic [K_W-1:0]     k_q, k_d;

  logic               cnt_load;
  logic               cnt_dec;
  logic [CNT_W-1:0]   cnt_val;
  logic               cnt_zero;

  logic               scan_on;
  logic [31:0]        ch_req_ext;
  logic [CH_W-1:0]    ch_req;
  logic [CH_W-1:0]    ch_next;

`ifdef SAR_ADC_SCAN_EN
  assign scan_on = bus.scanEn;
`else
  assign scan_on = 1'b0;
`endif

  // Requested channel, clamped to the last real channel when out of range.
  always_comb begin
    ch_req_ext = 32'(bus.chSel);
    if (ch_req_ext > 32'(NUM_CH - 1)) begin
      ch_req = MAX_CH;
    end else begin
      ch_req = bus.chSel;
    end
  end

  // Next channel in the round-robin scan order.
  assign ch_next = (chmux_q == MAX_CH) ? '0 : chmux_q + CH_W'(1);

  sar_adc_cnt #(
    .W (CNT_W)
  ) u_cnt (
    .clock  (clock),
    .reset  (reset),
    .load_i (cnt_load),
    .val_i  (cnt_val),
    .dec_i  (cnt_dec),
    .zero_o (cnt_zero)
  );

  // Next-state and registered-output logic of the conversion sequencer.
  always_comb begin
    state_d  = state_q;
    sh_d     = sh_q;
    chmux_d  = chmux_q;
    b_d      = b_q;
    nend_d   = nend_q;
    dout_d   = dout_q;
    dch_d    = dch_q;
    dvalid_d = dvalid_q;
    k_d      = k_q;
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;
    cnt_val  = SAMPLE_LD;

    case (state_q)
      ST_IDLE: begin
        if (scan_on || !bus.nStartCnv) begin
          chmux_d  = scan_on ? '0 : ch_req;
          sh_d     = 1'b1;
          nend_d   = 1'b1;
          b_d      = '0;
          cnt_load = 1'b1;
          cnt_val  = SAMPLE_LD;
          state_d  = ST_SAMPLE;
        end
      end
      ST_SAMPLE: begin
        if (cnt_zero) begin
          sh_d    = 1'b0;
          state_d = ST_HOLD;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      ST_HOLD: begin
        k_d     = TOP_K;
        state_d = ST_TRIAL;
      end
      ST_TRIAL: begin
        b_d[k_q] = 1'b1;
        if (SETTLE_CYCLES == 0) begin
          state_d = ST_DECIDE;
        end else begin
          cnt_load = 1'b1;
          cnt_val  = SETTLE_LD;
          state_d  = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (cnt_zero) begin
          state_d = ST_DECIDE;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      ST_DECIDE: begin
        if (bus.CompOut == COMP_ABOVE) begin
          b_d[k_q] = 1'b0;
        end
        if (k_q == '0) begin
          state_d = ST_STORE;
        end else begin
          k_d     = k_q - K_W'(1);
          state_d = ST_TRIAL;
        end
      end
      ST_STORE: begin
        dout_d   = b_q;
        dch_d    = chmux_q;
        dvalid_d = 1'b1;
        state_d  = ST_DONE;
      end
      ST_DONE: begin
        dvalid_d = 1'b0;
        if (scan_on) begin
          // Scanning: chain straight into the next channel's sample phase.
          chmux_d  = ch_next;
          sh_d     = 1'b1;
          b_d      = '0;
          cnt_load = 1'b1;
          cnt_val  = SAMPLE_LD;
          state_d  = ST_SAMPLE;
        end else begin
          nend_d  = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers; reset aborts any conversion in progress.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      sh_q     <= 1'b0;
      chmux_q  <= '0;
      b_q      <= '0;
      nend_q   <= 1'b0;
      dout_q   <= '0;
      dch_q    <= '0;
      dvalid_q <= 1'b0;
      k_q      <= '0;
    end else begin
      state_q  <= state_d;
      sh_q     <= sh_d;
      chmux_q  <= chmux_d;
      b_q      <= b_d;
      nend_q   <= nend_d;
      dout_q   <= dout_d;
      dch_q    <= dch_d;
      dvalid_q <= dvalid_d;
      k_q      <= k_d;
    end
  end

  assign bus.SH        = sh_q;
  assign bus.chMux     = chmux_q;
  assign bus.B         = b_q;
  assign bus.nEndCnv   = nend_q;
  assign bus.dataOut   = dout_q;
  assign bus.dataCh    = dch_q;
  assign bus.dataValid = dvalid_q;

endmodule

`default_nettype wire
